// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the pedal-board audio paths.
//   sample_t     : 16-bit two's-complement mono sample
//   SLOT_BITS    : bits per I2S channel slot
//   FRAME_BITS   : bits per I2S frame (left + right)
//   i2s_state_t  : serialiser state (IDLE, LEFT, RIGHT)
package audio_pkg;

    typedef logic [15:0] sample_t;

    localparam int SLOT_BITS  = 16;
    localparam int FRAME_BITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/bclk_gen.sv
// bclk_gen: divides Clk down to the I2S bit clock.
//   Clk       in  system clock
//   RESET     in  synchronous active-low reset
//   AUD_BCLK  out bit clock, toggles every BCLK_DIV Clk cycles (registered)
//   fall_tick out high for the one Clk cycle whose edge drives BCLK 1->0
// Parameter BCLK_DIV (>= 2): Clk cycles per BCLK half-period.
module bclk_gen #(
    parameter int BCLK_DIV = 8
) (
    input  logic Clk,
    input  logic RESET,
    output logic AUD_BCLK,
    output logic fall_tick
);

    localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] div_cnt_r;
    logic          bclk_r;
    logic          term_s;

    assign term_s = (div_cnt_r == TERM);

    // Half-period counter and bit clock register.
    always_ff @(posedge Clk) begin
        if (!RESET) begin
            div_cnt_r <= '0;
            bclk_r    <= 1'b0;
        end else if (term_s) begin
            div_cnt_r <= '0;
            bclk_r    <= ~bclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + ONE;
        end
    end

    // The tick marks the cycle whose clock edge takes BCLK low, so logic
    // updated on that edge changes together with the falling BCLK.
    assign fall_tick = term_s & bclk_r;
    assign AUD_BCLK  = bclk_r;

endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S master transmitter feeding the board audio DAC.
// Accepts one mono sample per frame through a one-entry holding register
// and sends it, MSB first with a one-BCLK delay, in both channel slots.
//   Clk          in  system clock (50 MHz)
//   RESET        in  synchronous active-low reset
//   sample_data  in  two's-complement mono sample
//   sample_valid in  sample_data valid
//   sample_ready out holding register empty (registered)
//   AUD_BCLK     out I2S bit clock
//   AUD_DACLRCK  out word select, 0 = left, 1 = right
//   AUD_DACDAT   out serial data, changes only as BCLK falls
//   underflow    out sticky: a frame started with no fresh sample
// Build option: define I2S_UNDERFLOW_MUTE_EN to send silence on underflow;
// otherwise the previous word is repeated.
// SAMPLE_W must equal SLOT_BITS; the slot bit selection assumes 16 bits.
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 8,
    parameter int SAMPLE_W = 16
) (
    input  logic                Clk,
    input  logic                RESET,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                underflow
);

    logic                fall_tick_s;
    i2s_state_t          state_r, state_nxt_s;
    logic [4:0]          k_r, k_nxt_s;
    logic [SAMPLE_W-1:0] hold_r, hold_nxt_s;
    logic                hold_full_r, hold_full_nxt_s;
    logic [SAMPLE_W-1:0] word_r, word_nxt_s;
    logic                prev_lsb_r, prev_lsb_nxt_s;
    logic                lrck_r, lrck_nxt_s;
    logic                dat_r, dat_nxt_s;
    logic                underflow_r, underflow_nxt_s;
    logic                ready_r;
    logic                take_s;
    logic                start_frame_s;
    logic [3:0]          bit_sel_s;

    bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .Clk       (Clk),
        .RESET     (RESET),
        .AUD_BCLK  (AUD_BCLK),
        .fall_tick (fall_tick_s)
    );

    assign take_s        = sample_valid & ~hold_full_r;
    assign start_frame_s = fall_tick_s & ((state_r == IDLE) | (k_r == 5'd0));
    // 16-k for k=1..15 and 32-k for k=17..31 share the same low four bits.
    assign bit_sel_s     = 4'd0 - k_r[3:0];

    // State register for all serialiser and handshake state.
    always_ff @(posedge Clk) begin
        if (!RESET) begin
            state_r     <= IDLE;
            k_r         <= 5'd0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            word_r      <= '0;
            prev_lsb_r  <= 1'b0;
            lrck_r      <= 1'b1;
            dat_r       <= 1'b0;
            underflow_r <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            hold_r      <= hold_nxt_s;
            hold_full_r <= hold_full_nxt_s;
            word_r      <= word_nxt_s;
            prev_lsb_r  <= prev_lsb_nxt_s;
            lrck_r      <= lrck_nxt_s;
            dat_r       <= dat_nxt_s;
            underflow_r <= underflow_nxt_s;
            ready_r     <= ~hold_full_nxt_s;
        end
    end

    // Next-state: frame sequencing, slot serialisation and holding register.
    always_comb begin
        state_nxt_s     = state_r;
        k_nxt_s         = k_r;
        hold_nxt_s      = hold_r;
        hold_full_nxt_s = hold_full_r;
        word_nxt_s      = word_r;
        prev_lsb_nxt_s  = prev_lsb_r;
        lrck_nxt_s      = lrck_r;
        dat_nxt_s       = dat_r;
        underflow_nxt_s = underflow_r;

        case (state_r)
            IDLE: begin
                if (start_frame_s) begin
                    state_nxt_s = LEFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LEFT: begin
                if (fall_tick_s && (k_r == 5'(SLOT_BITS))) begin
                    state_nxt_s = RIGHT;
                end else begin
                    state_nxt_s = LEFT;
                end
            end
            RIGHT: begin
                if (start_frame_s) begin
                    state_nxt_s = LEFT;
                end else begin
                    state_nxt_s = RIGHT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // Accept only into an empty register; a frame load in the same
        // cycle cannot collide because loading requires a full register.
        if (take_s) begin
            hold_nxt_s      = sample_data;
            hold_full_nxt_s = 1'b1;
        end else begin
            hold_nxt_s      = hold_r;
        end

        if (start_frame_s) begin
            k_nxt_s    = 5'd1;
            lrck_nxt_s = 1'b0;
            dat_nxt_s  = prev_lsb_r;
            if (hold_full_r) begin
                word_nxt_s      = hold_r;
                hold_full_nxt_s = 1'b0;
            end else begin
                underflow_nxt_s = 1'b1;
`ifdef I2S_UNDERFLOW_MUTE_EN
                word_nxt_s      = '0;
`else
                word_nxt_s      = word_r;
`endif
            end
        end else if (fall_tick_s) begin
            k_nxt_s = k_r + 5'd1;
            if (k_r == 5'(SLOT_BITS)) begin
                lrck_nxt_s = 1'b1;
                dat_nxt_s  = word_r[0];
            end else begin
                dat_nxt_s  = word_r[bit_sel_s];
            end
            // Right-slot LSB goes out at the next frame's first bit.
            if (k_r == 5'(FRAME_BITS - 1)) begin
                prev_lsb_nxt_s = word_r[0];
            end else begin
                prev_lsb_nxt_s = prev_lsb_r;
            end
        end else begin
            k_nxt_s = k_r;
        end
    end

    assign sample_ready = ready_r;
    assign AUD_DACLRCK  = lrck_r;
    assign AUD_DACDAT   = dat_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx (BCLK_DIV=2: 4 Clk per BCLK, 128 per frame).
module tb_i2s_dac_tx;

    localparam int DIV         = 2;
    localparam int FRAME_CLK   = 128;
    localparam int FIRST_FALL  = 4;
`ifdef I2S_UNDERFLOW_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] sample_data = 16'h0000;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic        underflow;

    i2s_dac_tx #(
        .BCLK_DIV (DIV),
        .SAMPLE_W (16)
    ) dut (
        .Clk          (Clk),
        .RESET        (RESET),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .underflow    (underflow)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] word;
        logic        uf;
    } frame_t;

    int          checks = 0;
    int          errors = 0;
    frame_t      exp_q[$];
    logic [15:0] pend_q[$];
    int          e = 0;          // Clk edges since reset release
    bit          rst_seen = 1'b0;
    logic [15:0] last_w = 16'h0000;
    logic        exp_uf = 1'b0;
    frame_t      mf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at e=%0d", name, act, req, e);
        end
    endtask

    // Reference model: frame starts fall at fixed Clk counts; each start
    // consumes the oldest accepted sample, otherwise it is an underflow.
    initial begin
        forever begin
            @(posedge Clk);
            if (!RESET) begin
                rst_seen = 1'b1;
                e        = 0;
                pend_q.delete();
                exp_q.delete();
                last_w   = 16'h0000;
                exp_uf   = 1'b0;
            end else begin
                rst_seen = 1'b0;
                e++;
                if (e >= FIRST_FALL && ((e - FIRST_FALL) % FRAME_CLK) == 0) begin
                    if (pend_q.size() > 0) begin
                        last_w = pend_q.pop_front();
                    end else begin
                        exp_uf = 1'b1;
                        if (MUTE) last_w = 16'h0000;
                    end
                    mf.word = last_w;
                    mf.uf   = exp_uf;
                    exp_q.push_back(mf);
                end
                if (sample_valid && sample_ready) pend_q.push_back(sample_data);
            end
        end
    end

    // Monitor: decodes the serial stream on BCLK rises and checks timing.
    initial begin
        logic        p_bclk, p_dat, p_lrck, rise_lrck_prev, fall, rise, have_right, lrck_seen;
        logic [15:0] lacc, racc, rexp;
        int          n, falls;
        frame_t      f;
        p_bclk = 1'b0; p_dat = 1'b0; p_lrck = 1'b1; rise_lrck_prev = 1'b1;
        have_right = 1'b0; lrck_seen = 1'b0; n = -1; falls = 0;
        lacc = 16'h0000; racc = 16'h0000; rexp = 16'h0000;
        forever begin
            @(negedge Clk);
            if (rst_seen) begin
                check("reset_vals", {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_ready, underflow}, 5'b01010);
                rise_lrck_prev = 1'b1; have_right = 1'b0; lrck_seen = 1'b0;
                n = -1; falls = 0;
            end else begin
                fall = p_bclk & ~AUD_BCLK;
                rise = ~p_bclk & AUD_BCLK;
                if (e == 3) check("pre_first_fall", {AUD_BCLK, AUD_DACLRCK}, 2'b11);
                if (e == 4) check("first_fall", {AUD_BCLK, AUD_DACLRCK}, 2'b00);
                if (fall) falls++;
                if (AUD_DACDAT !== p_dat) check("dat_on_fall", fall, 1);
                if (AUD_DACLRCK !== p_lrck) begin
                    check("lrck_on_fall", fall, 1);
                    if (lrck_seen) check("lrck_period", falls, 16);
                    lrck_seen = 1'b1;
                    falls     = 0;
                end
                if (rise) begin
                    if (!AUD_DACLRCK && rise_lrck_prev) n = 0;
                    else if (n >= 0) n++;
                    rise_lrck_prev = AUD_DACLRCK;
                    if (n == 0) begin
                        if (have_right) check("right_word", {racc[14:0], AUD_DACDAT}, rexp);
                        else check("first_lsb", AUD_DACDAT, 0);
                        have_right = 1'b0;
                    end else if (n >= 1 && n <= 16) begin
                        lacc = {lacc[14:0], AUD_DACDAT};
                        if (n == 16) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL left_word no expected frame, actual=%h", lacc);
                            end else begin
                                f = exp_q.pop_front();
                                check("left_word", lacc, f.word);
                                check("underflow", underflow, f.uf);
                                rexp = f.word;
                            end
                        end
                    end else if (n >= 17 && n <= 31) begin
                        racc = {racc[14:0], AUD_DACDAT};
                        if (n == 31) have_right = 1'b1;
                    end
                end
            end
            p_bclk = AUD_BCLK;
            p_dat  = AUD_DACDAT;
            p_lrck = AUD_DACLRCK;
        end
    end

    // Offers d until accepted (valid stays high afterwards); acc_e is the
    // accepting edge index, or -1 on timeout.
    task automatic push(input logic [15:0] d, output int acc_e);
        bit r;
        bit done;
        @(negedge Clk);
        sample_valid = 1'b1;
        sample_data  = d;
        done  = 1'b0;
        acc_e = -1;
        for (int t = 0; t < 600 && !done; t++) begin
            r = sample_ready;
            @(posedge Clk);
            #1;
            if (r) begin
                done  = 1'b1;
                acc_e = e;
                check("ready_drop", sample_ready, 0);
            end else begin
                @(negedge Clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=not accepted required=accepted data=%h", d);
        end
    endtask

    task automatic idle(input int cycles);
        @(negedge Clk);
        sample_valid = 1'b0;
        repeat (cycles) @(negedge Clk);
    endtask

    task automatic wait_edge(input int target);
        for (int t = 0; t < 4000 && e < target; t++) @(posedge Clk);
        #1;
    endtask

    initial begin
        int a, fs, gap;
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, fs, gap;
        RESET = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        RESET = 1'b1;

        push(16'h4AF3, a);
        push(16'hFA8D, a);
        check("accept_after_load", a, 5);
        idle(1);

        // Frame 2 has no sample: underflow must be flagged and stay set.
        wait_edge(FIRST_FALL + 3 * FRAME_CLK + 70);
        check("uf_sticky", underflow, exp_uf);

        // Reset while 0005 is in its right slot, with 1234 waiting in hold.
        push(16'h0005, a);
        fs = FIRST_FALL + FRAME_CLK * ((a - FIRST_FALL) / FRAME_CLK + 1);
        push(16'h1234, a);
        idle(0);
        wait_edge(fs + 81);
        @(negedge Clk);
        RESET = 1'b0;
        @(negedge Clk);
        RESET = 1'b1;
        check("uf_cleared", underflow, 0);
        push(16'h0BEE, a);
        idle(0);
        wait_edge(FIRST_FALL + 2 * FRAME_CLK + 10);

        for (int i = 0; i < 8; i++) begin
            gap = $urandom_range(0, 150);
            idle(gap);
            push(16'($urandom), a);
        end
        idle(0);
        wait_edge(e + 3 * FRAME_CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
